hsid_x_pixel_fetch: RTL

- OBI read master and unpacker directly upstream of the squared-difference/MSE datapath inside hsid_x_top.
- On start, it fetches the captured pixel once into a local word buffer.
- It then walks the library pixel by pixel. Each 32-bit word is unpacked into two 16-bit bands, and the block emits aligned (captured, reference) band pairs on a valid/ready stream.
- Each library pixel is tagged with its index, and the last band of each pixel is flagged.

---
 rtl/hsid_x_pixel_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hsid_x_pixel_fetch.sv
// ---------------------------------------------------------------------------
// hsid_x_pixel_fetch
//
// Purpose:
//   OBI read master and band unpacker that feeds the squared-difference/MSE
//   datapath. On start, it reads the captured pixel into a local word buffer.
//   It then walks the library one 32-bit word at a time and emits aligned
//   (captured, reference) 16-bit band pairs on a valid/ready stream.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start_i, abort_i              job control
//   captured_addr_i               captured pixel base address
//   library_addr_i                library base address
//   bands_i                       bands per pixel
//   library_size_i                number of library pixels
//   obi_*                         OBI read master (one outstanding read)
//   band_valid_o, band_ready_i    pair stream handshake
//   captured_band_o               captured sample
//   reference_band_o              library sample
//   band_last_o                   last band of the current pixel
//   pixel_idx_o                   index of the current library pixel
//   busy_o                        high whenever not idle
//   done_o                        one-cycle completion pulse
//   cfg_err_o                     sticky band-count error, cleared on start
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_i
// CHECK     | validate latched config
// CAP_REQ   | request captured word w
// CAP_RSP   | wait for captured word, store it in buffer[w]
// LIB_REQ   | request library word w of the current pixel
// LIB_RSP   | wait for library word, hold it
// EMIT_HI   | offer pair for band 2w   (upper halves)
// EMIT_LO   | offer pair for band 2w+1 (lower halves)
// NEXT      | advance word / pixel, or finish
// DONE      | pulse done_o
// ---------------------------------------------------------------------------
module hsid_x_pixel_fetch #(
    parameter int WORD_WIDTH        = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 8,
    parameter int MAX_BANDS         = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [WORD_WIDTH-1:0]        captured_addr_i,
    input  logic [WORD_WIDTH-1:0]        library_addr_i,
    input  logic [HSP_BANDS_WIDTH-1:0]   bands_i,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size_i,
    output logic                         obi_req_o,
    input  logic                         obi_gnt_i,
    output logic [WORD_WIDTH-1:0]        obi_addr_o,
    output logic                         obi_we_o,
    output logic [3:0]                   obi_be_o,
    input  logic                         obi_rvalid_i,
    input  logic [WORD_WIDTH-1:0]        obi_rdata_i,
    output logic                         band_valid_o,
    input  logic                         band_ready_i,
    output logic [DATA_WIDTH-1:0]        captured_band_o,
    output logic [DATA_WIDTH-1:0]        reference_band_o,
    output logic                         band_last_o,
    output logic [HSP_LIBRARY_WIDTH-1:0] pixel_idx_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         cfg_err_o
);

    localparam int BUF_DEPTH = MAX_BANDS / 2;
    localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [HSP_BANDS_WIDTH-1:0]   MAX_BANDS_C = HSP_BANDS_WIDTH'(MAX_BANDS);
    localparam logic [HSP_BANDS_WIDTH-1:0]   ONE_B       = HSP_BANDS_WIDTH'(1);
    localparam logic [HSP_LIBRARY_WIDTH-1:0] ONE_L       = HSP_LIBRARY_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0]        WORD_BYTES  = WORD_WIDTH'(4);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_CAP_REQ,
        S_CAP_RSP,
        S_LIB_REQ,
        S_LIB_RSP,
        S_EMIT_HI,
        S_EMIT_LO,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [HSP_BANDS_WIDTH-1:0]     bands_q, bands_d;
    logic [HSP_BANDS_WIDTH-1:0]     words_q, words_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   size_q, size_d;
    logic [WORD_WIDTH-1:0]          lib_base_q, lib_base_d;
    logic [WORD_WIDTH-1:0]          addr_q, addr_d;
    logic [HSP_BANDS_WIDTH-1:0]     word_idx_q, word_idx_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   pixel_idx_q, pixel_idx_d;
    logic [WORD_WIDTH-1:0]          lib_word_q, lib_word_d;
    logic [DATA_WIDTH-1:0]          cap_band_q, cap_band_d;
    logic [DATA_WIDTH-1:0]          ref_band_q, ref_band_d;
    logic                           last_q, last_d;
    logic                           req_q, req_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           cfg_err_q, cfg_err_d;
    logic                           abort_pend_q, abort_pend_d;

    logic [WORD_WIDTH-1:0]          buf_mem [BUF_DEPTH];
    logic                           buf_we;
    logic [WORD_WIDTH-1:0]          buf_rd;
    logic                           last_word;

    assign buf_rd    = buf_mem[word_idx_q[BUF_AW-1:0]];
    assign last_word = (word_idx_q == (words_q - ONE_B));

    always_comb begin
        state_d      = state_q;
        bands_d      = bands_q;
        words_d      = words_q;
        size_d       = size_q;
        lib_base_d   = lib_base_q;
        addr_d       = addr_q;
        word_idx_d   = word_idx_q;
        pixel_idx_d  = pixel_idx_q;
        lib_word_d   = lib_word_q;
        cap_band_d   = cap_band_q;
        ref_band_d   = ref_band_q;
        last_d       = last_q;
        cfg_err_d    = cfg_err_q;
        abort_pend_d = abort_pend_q;
        buf_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort_i is ignored here, so start wins when both are high
                if (start_i) begin
                    bands_d      = bands_i;
                    words_d      = (bands_i >> 1) + HSP_BANDS_WIDTH'(bands_i[0]);
                    size_d       = library_size_i;
                    addr_d       = captured_addr_i;
                    lib_base_d   = library_addr_i;
                    word_idx_d   = '0;
                    pixel_idx_d  = '0;
                    cfg_err_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = S_CHECK;
                end
            end

            S_CHECK: begin
                if (bands_q == '0 || size_q == '0) begin
                    state_d = S_DONE;
                end else if (bands_q > MAX_BANDS_C) begin
                    cfg_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_CAP_REQ;
                end
            end

            S_CAP_REQ, S_LIB_REQ: begin
                // A grant coinciding with abort leaves a read in flight, so
                // the response is still drained before returning to idle.
                if (obi_gnt_i) begin
                    abort_pend_d = abort_i;
                    state_d      = (state_q == S_CAP_REQ) ? S_CAP_RSP : S_LIB_RSP;
                end else if (abort_i) begin
                    state_d = S_IDLE;
                end
            end

            S_CAP_RSP: begin
                if (obi_rvalid_i) begin
                    if (abort_i || abort_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        buf_we = 1'b1;
                        if (last_word) begin
                            word_idx_d = '0;
                            addr_d     = lib_base_q;
                            state_d    = S_LIB_REQ;
                        end else begin
                            word_idx_d = word_idx_q + ONE_B;
                            addr_d     = addr_q + WORD_BYTES;
                            state_d    = S_CAP_REQ;
                        end
                    end
                end else if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
            end

            S_LIB_RSP: begin
                if (obi_rvalid_i) begin
                    if (abort_i || abort_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        lib_word_d = obi_rdata_i;
                        addr_d     = addr_q + WORD_BYTES;
                        cap_band_d = buf_rd[2*DATA_WIDTH-1:DATA_WIDTH];
                        ref_band_d = obi_rdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
                        // upper half is the last band only for odd band counts
                        last_d     = last_word && bands_q[0];
                        state_d    = S_EMIT_HI;
                    end
                end else if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
            end

            S_EMIT_HI: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (band_ready_i) begin
                    if ({word_idx_q, 1'b1} < {1'b0, bands_q}) begin
                        cap_band_d = buf_rd[DATA_WIDTH-1:0];
                        ref_band_d = lib_word_q[DATA_WIDTH-1:0];
                        last_d     = last_word;
                        state_d    = S_EMIT_LO;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end

            S_EMIT_LO: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (band_ready_i) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (!last_word) begin
                    word_idx_d = word_idx_q + ONE_B;
                    state_d    = S_LIB_REQ;
                end else if (pixel_idx_q != (size_q - ONE_L)) begin
                    pixel_idx_d = pixel_idx_q + ONE_L;
                    word_idx_d  = '0;
                    state_d     = S_LIB_REQ;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_d   = (state_d == S_CAP_REQ) || (state_d == S_LIB_REQ);
        valid_d = (state_d == S_EMIT_HI) || (state_d == S_EMIT_LO);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bands_q      <= '0;
            words_q      <= '0;
            size_q       <= '0;
            lib_base_q   <= '0;
            addr_q       <= '0;
            word_idx_q   <= '0;
            pixel_idx_q  <= '0;
            lib_word_q   <= '0;
            cap_band_q   <= '0;
            ref_band_q   <= '0;
            last_q       <= 1'b0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bands_q      <= bands_d;
            words_q      <= words_d;
            size_q       <= size_d;
            lib_base_q   <= lib_base_d;
            addr_q       <= addr_d;
            word_idx_q   <= word_idx_d;
            pixel_idx_q  <= pixel_idx_d;
            lib_word_q   <= lib_word_d;
            cap_band_q   <= cap_band_d;
            ref_band_q   <= ref_band_d;
            last_q       <= last_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Captured-pixel buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[word_idx_q[BUF_AW-1:0]] <= obi_rdata_i;
        end
    end

    assign obi_req_o        = req_q;
    assign obi_addr_o       = addr_q;
    assign obi_we_o         = 1'b0;
    assign obi_be_o         = 4'hF;
    assign band_valid_o     = valid_q;
    assign captured_band_o  = cap_band_q;
    assign reference_band_o = ref_band_q;
    assign band_last_o      = last_q;
    assign pixel_idx_o      = pixel_idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign cfg_err_o        = cfg_err_q;

endmodule
